route_arbiter: RTL
==================

// Module: route_arbiter
// PURPOSE
//  Sits directly downstream of the per-input request FSMs: consumes request_i/address_i/release_i, returns grant/deny.
//  XY-routes each request to one output port, arbitrates round-robin per output, locks the winner until release.
//  Drives per-output owner select to the crossbar.
// PARAMETERS
//  NPORTS   5       ports; index 0=LOCAL 1=NORTH 2=EAST 3=SOUTH 4=WEST
//  ADDRYX   8       destination address width; [7:4]=Y, [3:0]=X
//  SELW     3       owner-index width, ceil(log2(NPORTS))
//  LOCAL_X  4'b0010 this router's X coordinate
//  LOCAL_Y  4'b0010 this router's Y coordinate
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-low
//  request_i  in   NPORTS         per-input request level (held while input waits)
//  address_i  in   NPORTS*ADDRYX  per-input destination {Y,X}; input p at [p*ADDRYX +: ADDRYX]
//  release_i  in   NPORTS         per-input teardown (stb low, cancel or fail); level-sensitive
//  grant_o    out  NPORTS         one-cycle grant pulse to input p
//  deny_o     out  NPORTS         one-cycle deny pulse to input p
//  busy_o     out  NPORTS         output q currently owned
//  sel_o      out  NPORTS*SELW    owning input index of output q (crossbar select); 0 when free
// BEHAVIOUR
//  - Reset (reset low, async): all owners cleared, busy_o/sel_o/grant_o/deny_o = 0, RR pointers = 0.
//    Reset mid-connection drops every lock immediately. No pulse is emitted on reset exit.
//  - Route (combinational, unsigned 4-bit compare): X>LOCAL_X->EAST; X<LOCAL_X->WEST;
//    else Y>LOCAL_Y->NORTH; Y<LOCAL_Y->SOUTH; else LOCAL.
//  - Per-output FSM, 2 states:
//    FREE -> BUSY on grant; owner := winner, ptr := (winner+1) mod NPORTS.
//    BUSY -> FREE when release_i[owner]=1.
//  - Decision made in cycle t from registered state; grant_o/deny_o registered, visible in t+1 (latency 1).
//    Each is a single-cycle pulse.
//  - Per input p with request_i[p]=1 and release_i[p]=0, target q:
//    q==p and p!=LOCAL (U-turn)              -> deny.
//    q BUSY, owner==p                        -> ignored: no grant, no deny (request still high after grant).
//    q BUSY, owner!=p                        -> deny.
//    q FREE, p wins RR                       -> grant.
//    q FREE, p loses RR                      -> deny.
//  - RR winner: first requester at index ptr, ptr+1, ... wrapping at NPORTS-1 -> 0.
//  - Input p owning output r that requests a different q (second-stage re-route):
//    r is freed in t+1 regardless of the outcome for q.
//  - Release vs request on the same input in the same cycle: release wins, request ignored that cycle.
//  - Freed output: arbitrable from the cycle after busy_o drops; no same-cycle release+grant.
//  - Invariants, each cycle: grant_o and deny_o never both high for one input; at most one owner per output.
// STRUCTURE
//  - Shared header router_defs.vh: port index constants (P_LOCAL..P_WEST), NPORTS, SELW, ADDRYX field positions.
//  - Sub-module rr_arbiter (NPORTS-bit request vector + pointer in, one-hot winner out), one instance per output.
//  - Top holds route decode, per-output owner/busy/ptr registers, grant/deny registers.
// TESTING
//  1 Reset: assert reset low with output 2 owned -> busy_o=0, sel_o=0 same cycle; no grant/deny pulse after release.
//  2 Single grant: LOCAL(0) requests addr 8'h24 (X=4>2) -> grant_o=5'b00001 next cycle, busy_o[2]=1, sel_o[2]=0;
//    holding request afterwards -> no further pulse.
//  3 Contention: inputs 1 and 3 both request addr 8'h20 (WEST) in the same cycle, ptr=0
//    -> grant_o[1]=1, deny_o[3]=1, ptr=2.
//    Repeat after release -> input 3 wins.
//  4 Busy: output EAST owned by 0, input 4 requests 8'h27 -> deny_o[4] pulse; busy/sel unchanged.
//  5 U-turn: input 1 (NORTH) requests 8'h32 (Y=3, routes NORTH) -> deny_o[1].
//    Input 0 requesting 8'h22 -> grant, target LOCAL.
//  6 Release/reuse: owner 0 asserts release_i[0] with request_i[0] high -> busy_o[2]=0 next cycle, no grant.
//    New request from 4 to EAST is granted one cycle later.

Source files
------------

// File: rtl/route_arbiter_pkg.sv
// Shared router definitions: port indices, field positions, XY route decode and small index helpers.
package route_arbiter_pkg;

  localparam int NPORTS = 5;
  localparam int ADDRYX = 8;
  localparam int SELW   = 3;
  localparam int COORDW = 4;
  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 4;

  typedef logic [SELW-1:0]   port_t;
  typedef logic [COORDW-1:0] coord_t;

  localparam port_t P_LOCAL = 3'd0;
  localparam port_t P_NORTH = 3'd1;
  localparam port_t P_EAST  = 3'd2;
  localparam port_t P_SOUTH = 3'd3;
  localparam port_t P_WEST  = 3'd4;

  typedef enum logic {OUT_FREE = 1'b0, OUT_BUSY = 1'b1} out_state_e;

  // X is resolved before Y; equal coordinates on both axes terminate locally.
  function automatic port_t xy_route(input logic [ADDRYX-1:0] addr,
                                     input coord_t lx, input coord_t ly);
    coord_t x;
    coord_t y;
    x = addr[X_LSB +: COORDW];
    y = addr[Y_LSB +: COORDW];
    if (x > lx)      return P_EAST;
    else if (x < lx) return P_WEST;
    else if (y > ly) return P_NORTH;
    else if (y < ly) return P_SOUTH;
    else             return P_LOCAL;
  endfunction

  function automatic port_t onehot_idx(input logic [NPORTS-1:0] oh);
    port_t idx;
    idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) idx = port_t'(i);
    end
    return idx;
  endfunction

  function automatic port_t ptr_after(input port_t p);
    return (p == port_t'(NPORTS-1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/route_arbiter_rr.sv
// Round-robin picker: first set request at ptr, ptr+1, ... wrapping; one-hot result.
// Purely combinational.
module rr_arbiter
  import route_arbiter_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  port_t             ptr,
  output logic [NPORTS-1:0] gnt
);

  port_t idx;
  logic  found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = ptr_after(idx);
    end
  end

endmodule

// File: rtl/route_arbiter.sv
// XY-routes per-input requests, arbitrates each output round-robin and locks the winner until release.
// Grant/deny are registered one-cycle pulses (latency 1); requesters just hold request_i while waiting.
module route_arbiter
  import route_arbiter_pkg::*;
#(
  parameter coord_t LOCAL_X = 4'b0010,
  parameter coord_t LOCAL_Y = 4'b0010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        request_i,
  input  logic [NPORTS*ADDRYX-1:0] address_i,
  input  logic [NPORTS-1:0]        release_i,
  output logic [NPORTS-1:0]        grant_o,
  output logic [NPORTS-1:0]        deny_o,
  output logic [NPORTS-1:0]        busy_o,
  output logic [NPORTS*SELW-1:0]   sel_o
);

  localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

  port_t             target [NPORTS];
  logic [NPORTS-1:0] active;
  logic [NPORTS-1:0] uturn;
  logic [NPORTS-1:0] cand   [NPORTS];
  logic [NPORTS-1:0] win    [NPORTS];

  out_state_e        state_q [NPORTS];
  out_state_e        state_d [NPORTS];
  port_t             owner_q [NPORTS];
  port_t             owner_d [NPORTS];
  port_t             ptr_q   [NPORTS];
  port_t             ptr_d   [NPORTS];
  logic [NPORTS-1:0] grant_d;
  logic [NPORTS-1:0] deny_d;

  // Release on an input masks its request for that cycle.
  always_comb begin
    active = '0;
    uturn  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      target[p] = xy_route(address_i[p*ADDRYX +: ADDRYX], LOCAL_X, LOCAL_Y);
      active[p] = request_i[p] & ~release_i[p];
      uturn[p]  = (target[p] == port_t'(p)) && (port_t'(p) != P_LOCAL);
    end
    for (int q = 0; q < NPORTS; q++) begin
      cand[q] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        cand[q][p] = active[p] & ~uturn[p] & (target[p] == port_t'(q));
      end
    end
  end

  for (genvar q = 0; q < NPORTS; q++) begin : g_rr
    rr_arbiter u_rr (
      .req (cand[q]),
      .ptr (ptr_q[q]),
      .gnt (win[q])
    );
  end

  always_comb begin
    grant_d = '0;
    deny_d  = uturn & active;
    for (int q = 0; q < NPORTS; q++) begin
      state_d[q] = state_q[q];
      owner_d[q] = owner_q[q];
      ptr_d[q]   = ptr_q[q];
      case (state_q[q])
        OUT_FREE: begin
          grant_d = grant_d | win[q];
          deny_d  = deny_d | (cand[q] & ~win[q]);
          if (|win[q]) begin
            state_d[q] = OUT_BUSY;
            owner_d[q] = onehot_idx(win[q]);
            ptr_d[q]   = ptr_after(onehot_idx(win[q]));
          end
        end
        default: begin
          // The owner's own held request is neither granted nor denied.
          deny_d = deny_d | (cand[q] & ~(ONE << owner_q[q]));
          // Owner steering elsewhere (second-stage re-route) also gives this output up.
          if (release_i[owner_q[q]] ||
              (active[owner_q[q]] && (target[owner_q[q]] != port_t'(q)))) begin
            state_d[q] = OUT_FREE;
            owner_d[q] = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NPORTS; q++) begin
        state_q[q] <= OUT_FREE;
        owner_q[q] <= '0;
        ptr_q[q]   <= '0;
      end
      grant_o <= '0;
      deny_o  <= '0;
    end else begin
      for (int q = 0; q < NPORTS; q++) begin
        state_q[q] <= state_d[q];
        owner_q[q] <= owner_d[q];
        ptr_q[q]   <= ptr_d[q];
      end
      grant_o <= grant_d;
      deny_o  <= deny_d;
    end
  end

  always_comb begin
    busy_o = '0;
    sel_o  = '0;
    for (int q = 0; q < NPORTS; q++) begin
      busy_o[q]              = (state_q[q] == OUT_BUSY);
      sel_o[q*SELW +: SELW]  = owner_q[q];
    end
  end

endmodule
